// File: rtl/bus_master_port.sv
// bus_master_port: master endpoint of the bit-serial system bus.
// Serialises {addr, wdata} MSB-first and shifts read data back in.
module bus_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  split
);

  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int BW = $clog2(SW + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] A_LAST = BW'(ADDR_WIDTH - 1);
  localparam logic [BW-1:0] D_LAST = BW'(SW - 1);
  localparam logic [BW-1:0] R_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_RDATA,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [SW-1:0]         sh_q, sh_n;
  logic                  mode_q, mode_n;
  logic [BW-1:0]         bit_q, bit_n;
  logic [TW-1:0]         to_q, to_n;
  logic [DATA_WIDTH-1:0] rd_q, rd_n;
  logic                  err_q, err_n;
  logic                  to_hit;
  logic [TW-1:0]         to_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sh_q   <= '0;
      mode_q <= 1'b0;
      bit_q  <= '0;
      to_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      sh_q   <= sh_n;
      mode_q <= mode_n;
      bit_q  <= bit_n;
      to_q   <= to_n;
      rd_q   <= rd_n;
      err_q  <= err_n;
    end
  end

  // Expiry fires on the TIMEOUT-th wait cycle; counter saturates.
  assign to_hit = TO_EN && (to_q == TO_LAST);
  assign to_inc = (to_q != TO_MAX) ? to_q + TW'(1) : to_q;

  always_comb begin
    state_n = state;
    sh_n    = sh_q;
    mode_n  = mode_q;
    bit_n   = bit_q;
    to_n    = to_q;
    rd_n    = rd_q;
    err_n   = err_q;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          sh_n    = {req_addr, req_wdata};
          mode_n  = req_mode;
          bit_n   = '0;
          to_n    = '0;
          rd_n    = '0;
          err_n   = 1'b0;
          state_n = S_REQ;
        end
      end
      S_REQ, S_ADDR, S_DATA: begin
        if (slave_ready) begin
          sh_n  = sh_q << 1;
          bit_n = bit_q + BW'(1);
          if (bit_q == D_LAST) begin
            state_n = S_DONE;
          end else if (bit_q == A_LAST) begin
            if (mode_q) begin
              state_n = S_DATA;
            end else begin
              state_n = S_WAIT;
              to_n    = '0;
              bit_n   = '0;
            end
          end else if (state == S_REQ) begin
            state_n = S_ADDR;
          end
        end else if (state == S_REQ) begin
          if (to_hit) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            to_n = to_inc;
          end
        end else begin
          // Slave dropped ready mid-burst: transfer abandoned.
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_WAIT: begin
        if (slave_valid) begin
          rd_n    = DATA_WIDTH'({rd_q, rd_bus});
          bit_n   = BW'(1);
          state_n = (R_LAST == '0) ? S_DONE : S_RDATA;
        end else if (!split) begin
          if (to_hit) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            to_n = to_inc;
          end
        end
      end
      S_RDATA: begin
        if (slave_valid) begin
          rd_n  = DATA_WIDTH'({rd_q, rd_bus});
          bit_n = bit_q + BW'(1);
          if (bit_q == R_LAST) state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign req_ready    = (state == S_IDLE);
  assign master_valid = (state == S_REQ) || (state == S_ADDR) ||
                        (state == S_DATA);
  assign master_ready = (state == S_WAIT) || (state == S_RDATA);
  assign wr_bus       = master_valid & sh_q[SW-1];
  assign mode         = (state != S_IDLE) & mode_q;
  assign resp_valid   = (state == S_DONE);
  assign resp_err     = resp_valid & err_q;
  assign resp_rdata   = (resp_valid && !err_q && !mode_q) ? rd_q : '0;

endmodule
